// File: rtl/cpu68k_pkg.sv
// ---------------------------------------------------------------------------
// cpu68k_pkg: shared types and constants for the 68000 bus controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu68k_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACK  = 3'd2,
    ST_VPA  = 3'd3,
    ST_BERR = 3'd4
  } bus_state_e;

  localparam logic [2:0] FC_IACK = 3'b111;
  localparam int         MAX_IRQ = 7;

  // Highest set bit i maps to level i+1; returned active-low as the 68k IPL lines expect.
  function automatic logic [2:0] ipl_encode(input logic [MAX_IRQ-1:0] pend);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (pend[i]) lvl = 3'(i + 1);
    end
    return ~lvl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu68k_irq_enc.sv
// ---------------------------------------------------------------------------
// cpu68k_irq_enc: interrupt pending latch and registered IPL priority encoder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu68k_irq_enc
  import cpu68k_pkg::*;
#(
  parameter int NUM_IRQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_set_i,
  input  logic [NUM_IRQ-1:0] irq_ack_i,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [2:0]         ipl_o
);

  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [MAX_IRQ-1:0] pend_ext;
  logic [2:0]         ipl_q;

  // Set is applied after the clear so a simultaneous set/ack leaves the bit pending.
  assign pend_d = (pend_q & ~irq_ack_i) | irq_set_i;

  generate
    if (NUM_IRQ < MAX_IRQ) begin : g_pad
      assign pend_ext = {{(MAX_IRQ - NUM_IRQ){1'b0}}, pend_d};
    end else begin : g_full
      assign pend_ext = pend_d;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      ipl_q  <= 3'b111;
    end else begin
      pend_q <= pend_d;
      ipl_q  <= ipl_encode(pend_ext);
    end
  end

  assign pending_o = pend_q;
  assign ipl_o     = ipl_q;

endmodule

`default_nettype wire

// File: rtl/cpu68k_bus_ctrl.sv
// ---------------------------------------------------------------------------
// cpu68k_bus_ctrl: fx68k clock enables, reset stretcher, DTACK/VPA/BERR and IPL. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu68k_bus_ctrl
  import cpu68k_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int RST_CYC = 4,
  parameter int WAIT_W  = 2,
  parameter int TIMEOUT = 64,
  parameter int NUM_IRQ = 3
) (
  input  logic               CLK_24M,
  input  logic               nRESET,
  output logic               EN_PHI1,
  output logic               EN_PHI2,
  output logic               CPU_RESET,
  input  logic               nAS,
  input  logic               nUDS,
  input  logic               nLDS,
  input  logic               M68K_RW,
  input  logic [2:0]         FC,
  input  logic [WAIT_W-1:0]  WAIT_CNT,
  input  logic               nEXT_WAIT,
  output logic               nDTACK,
  output logic               nVPA,
  output logic               nBERR,
  input  logic [NUM_IRQ-1:0] IRQ_SET,
  input  logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic [NUM_IRQ-1:0] IRQ_PENDING,
  output logic               IPL2n,
  output logic               IPL1n,
  output logic               IPL0n
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic [CW-1:0]     phase_q, phase_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  bus_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [2:0]        ipl;
  logic              unused_strobes;

  // Data strobes and direction do not affect the handshake; the decoder uses them.
  assign unused_strobes = ^{nUDS, nLDS, M68K_RW};

  assign phase_d   = (phase_q == CW'(CLK_DIV - 1)) ? '0 : phase_q + CW'(1);
  assign EN_PHI1   = (phase_q == '0);
  assign EN_PHI2   = (phase_q == CW'(CLK_DIV / 2));
  assign CPU_RESET = cpu_rst_q;

  always_comb begin
    rcnt_d    = rcnt_q;
    cpu_rst_d = cpu_rst_q;
    if (cpu_rst_q && EN_PHI2) begin
      if (rcnt_q == RW'(RST_CYC - 1)) cpu_rst_d = 1'b0;
      else                            rcnt_d    = rcnt_q + RW'(1);
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      phase_q   <= '0;
      rcnt_q    <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      rcnt_q    <= rcnt_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    if (EN_PHI2) begin
      if (nAS) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (FC == FC_IACK) begin
              state_d = ST_VPA;
            end else begin
              state_d = ST_WAIT;
              wcnt_d  = WAIT_CNT;
              tcnt_d  = '0;
            end
          end
          ST_WAIT: begin
            // Timeout wins over a completing wait on the same enable.
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
              state_d = ST_BERR;
            end else begin
              tcnt_d = tcnt_q + TW'(1);
              if (wcnt_q != '0)   wcnt_d  = wcnt_q - WAIT_W'(1);
              else if (nEXT_WAIT) state_d = ST_ACK;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    nDTACK = 1'b1;
    nVPA   = 1'b1;
    nBERR  = 1'b1;
    case (state_q)
      ST_ACK:  nDTACK = 1'b0;
      ST_VPA:  nVPA   = 1'b0;
      ST_BERR: nBERR  = 1'b0;
      default: ;
    endcase
  end

  cpu68k_irq_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_enc (
    .clk_i     (CLK_24M),
    .rst_ni    (nRESET),
    .irq_set_i (IRQ_SET),
    .irq_ack_i (IRQ_ACK),
    .pending_o (IRQ_PENDING),
    .ipl_o     (ipl)
  );

  assign {IPL2n, IPL1n, IPL0n} = ipl;

endmodule

`default_nettype wire

// File: tb/tb_cpu68k_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu68k_bus_ctrl: scoreboard bench for cpu68k_bus_ctrl (CLK_DIV 2 and 6). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu68k_bus_ctrl;

  localparam int TIMEOUT = 64;
  localparam int RST_CYC = 4;
  localparam int DIVS [2] = '{2, 6};

  typedef struct { int kind; int lat; } exp_t;
  typedef struct { logic [2:0] pend; logic [2:0] ipl; } iexp_t;

  logic       clk = 1'b0;
  logic       nRESET = 1'b1;
  logic       nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, rw = 1'b1, nEXT = 1'b1;
  logic [2:0] fc = 3'd0;
  logic [1:0] wc = 2'd0;
  logic [2:0] irq_set = 3'd0, irq_ack = 3'd0;
  logic [1:0] en1, en2, crst;
  logic       dtack, vpa, berr, dtack6, vpa6, berr6;
  logic [2:0] pend, pend6;
  logic       i2, i1, i0, j2, j1, j0;

  int    vec = 0, errs = 0;
  int    ph [2];
  int    n2 [2];
  bit    chk_ph = 0, mon_on = 0;
  exp_t  bq [$];
  iexp_t iq [$];
  logic [2:0] mpend = 3'd0;

  always #5 clk = ~clk;

  cpu68k_bus_ctrl #(.CLK_DIV(2), .RST_CYC(RST_CYC), .WAIT_W(2), .TIMEOUT(TIMEOUT), .NUM_IRQ(3)) u_dut (
    .CLK_24M(clk), .nRESET(nRESET), .EN_PHI1(en1[0]), .EN_PHI2(en2[0]), .CPU_RESET(crst[0]),
    .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(rw), .FC(fc), .WAIT_CNT(wc), .nEXT_WAIT(nEXT),
    .nDTACK(dtack), .nVPA(vpa), .nBERR(berr), .IRQ_SET(irq_set), .IRQ_ACK(irq_ack),
    .IRQ_PENDING(pend), .IPL2n(i2), .IPL1n(i1), .IPL0n(i0));

  cpu68k_bus_ctrl #(.CLK_DIV(6), .RST_CYC(RST_CYC), .WAIT_W(2), .TIMEOUT(TIMEOUT), .NUM_IRQ(3)) u_dut6 (
    .CLK_24M(clk), .nRESET(nRESET), .EN_PHI1(en1[1]), .EN_PHI2(en2[1]), .CPU_RESET(crst[1]),
    .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(rw), .FC(fc), .WAIT_CNT(wc), .nEXT_WAIT(nEXT),
    .nDTACK(dtack6), .nVPA(vpa6), .nBERR(berr6), .IRQ_SET(irq_set), .IRQ_ACK(irq_ack),
    .IRQ_PENDING(pend6), .IPL2n(j2), .IPL1n(j1), .IPL0n(j0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response pattern {nBERR,nVPA,nDTACK} for DTACK / VPA / BERR.
  function automatic logic [2:0] rsp_of(input int k);
    case (k)
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  // Reference phase: CPU-clock position of each instance since reset release.
  always @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      for (int d = 0; d < 2; d++) begin ph[d] = 0; n2[d] = 0; end
    end else begin
      for (int d = 0; d < 2; d++) ph[d] = (ph[d] + 1) % DIVS[d];
    end
  end

  always @(negedge clk) begin
    if (nRESET && chk_ph) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("en_phi1[div%0d]", DIVS[d]), en1[d], ph[d] == 0);
        chk($sformatf("en_phi2[div%0d]", DIVS[d]), en2[d], ph[d] == DIVS[d] / 2);
        chk($sformatf("phi_excl[div%0d]", DIVS[d]), en1[d] & en2[d], 1'b0);
        if (n2[d] <= RST_CYC + 1)
          chk($sformatf("cpu_reset[div%0d]", DIVS[d]), crst[d], n2[d] < RST_CYC);
        if (en2[d]) n2[d]++;
      end
    end
  end

  // Bus monitor: counts EN_PHI2 edges seen with nAS low and pops on each response.
  int   mphase = 0, pulses = 0, mkind = 0;
  logic last_en = 1'b0, last_nas = 1'b1;
  always @(negedge clk) begin : bus_mon
    logic [2:0] rsp;
    exp_t e;
    rsp = {berr, vpa, dtack};
    if (mon_on) begin
      if (mphase == 1 && last_en && !last_nas) pulses++;
      case (mphase)
        0: chk("idle_rsp", rsp, 3'b111);
        1: if (rsp != 3'b111) begin
             if (bq.size() == 0) begin
               chk("unexpected_rsp", rsp, 3'b111);
             end else begin
               e = bq.pop_front();
               chk("rsp_kind", rsp, rsp_of(e.kind));
               chk("rsp_latency", pulses, e.lat);
               mkind = e.kind;
             end
             mphase = 2;
           end
        default: begin
          if (last_en && last_nas) begin
            chk("rsp_release", rsp, 3'b111);
            mphase = 0;
          end else begin
            chk("rsp_hold", rsp, rsp_of(mkind));
          end
        end
      endcase
      if (mphase == 0 && !nAS) begin
        mphase = 1;
        pulses = 0;
      end
    end
    last_en  = en2[0];
    last_nas = nAS;
  end

  always @(negedge clk) begin : irq_mon
    iexp_t x;
    if (iq.size() > 0) begin
      x = iq.pop_front();
      chk("irq_pending", pend, x.pend);
      chk("ipl", {i2, i1, i0}, x.ipl);
    end
  end

  task automatic irq_op(input logic [2:0] s, input logic [2:0] a);
    iexp_t x;
    int    lvl;
    @(posedge clk); #2;
    irq_set = s;
    irq_ack = a;
    for (int i = 0; i < 3; i++) begin
      if (s[i])      mpend[i] = 1'b1;
      else if (a[i]) mpend[i] = 1'b0;
    end
    lvl = 0;
    for (int i = 2; i >= 0; i--) if (mpend[i] && lvl == 0) lvl = i + 1;
    x.pend = mpend;
    x.ipl  = 3'(7 - lvl);
    @(posedge clk); #1;
    irq_set = 3'd0;
    irq_ack = 3'd0;
    iq.push_back(x);
  endtask

  task automatic bus_cycle(input logic [2:0] f, input logic [1:0] w, input logic ext, input int hold);
    exp_t e;
    int   t;
    if (f == 3'b111)                    begin e.kind = 1; e.lat = 1;           end
    else if (ext && (w + 1 < TIMEOUT))  begin e.kind = 0; e.lat = 2 + w;       end
    else                                begin e.kind = 2; e.lat = 1 + TIMEOUT; end
    @(posedge clk); #2;
    fc = f; wc = w; nEXT = ext; nAS = 1'b0;
    bq.push_back(e);
    t = 0;
    while ({berr, vpa, dtack} == 3'b111 && t < 400) begin @(posedge clk); #2; t++; end
    if (t >= 400) chk("rsp_wait_bound", {berr, vpa, dtack}, rsp_of(e.kind));
    repeat (hold) begin @(posedge clk); #2; end
    nAS = 1'b1;
    t = 0;
    while ({berr, vpa, dtack} != 3'b111 && t < 50) begin @(posedge clk); #2; t++; end
    if (t >= 50) chk("release_wait_bound", {berr, vpa, dtack}, 3'b111);
    nEXT = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1 nRESET = 1'b0;
    @(negedge clk);
    chk("rst_cpu_reset", crst, 2'b11);
    chk("rst_rsp", {berr, vpa, dtack}, 3'b111);
    chk("rst_pending", pend, 3'b000);
    chk("rst_ipl", {i2, i1, i0}, 3'b111);
    @(posedge clk); #2;
    nRESET = 1'b1;
    chk_ph = 1;
    mon_on = 1;
    repeat (40) @(posedge clk);

    irq_op(3'b011, 3'b000);
    irq_op(3'b000, 3'b010);
    irq_op(3'b001, 3'b001);
    repeat (16) irq_op(3'($urandom), 3'($urandom));
    irq_op(3'b010, 3'b000);

    bus_cycle(3'b101, 2'd0, 1'b1, 0);
    bus_cycle(3'b101, 2'd3, 1'b1, 2);
    bus_cycle(3'b111, 2'd0, 1'b1, 1);
    irq_op(3'b000, 3'b000);
    bus_cycle(3'b110, 2'd1, 1'b0, 0);
    for (int k = 0; k < 20; k++)
      bus_cycle(3'($urandom_range(0, 7)), 2'($urandom), ($urandom % 8) != 0, $urandom_range(0, 3));
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", bq.size(), 0);

    // Asynchronous reset in the middle of an acknowledged cycle.
    mon_on = 0;
    irq_op(3'b100, 3'b000);
    @(posedge clk); #2;
    fc = 3'b101; wc = 2'd0; nEXT = 1'b1; nAS = 1'b0;
    for (int t = 0; t < 20 && dtack; t++) begin @(posedge clk); #2; end
    chk("pre_reset_dtack", dtack, 1'b0);
    #1 nRESET = 1'b0;
    #1;
    chk("async_rst_dtack", dtack, 1'b1);
    chk("async_rst_pending", pend, 3'b000);
    chk("async_rst_ipl", {i2, i1, i0}, 3'b111);
    chk("async_rst_cpu_reset", crst, 2'b11);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_rsp", {berr, vpa, dtack}, 3'b111);
    end
    nAS = 1'b1;
    bq.delete();
    @(posedge clk); #2;
    nRESET = 1'b1;
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
